image_pixel_streamer: RTL

Source-side companion of the systolic convolution top. It holds one IMG_WIDTH×IMG_HEIGHT frame in a local pixel buffer, loaded through a simple write port. On `start` it replays the frame in raster order, one pixel per clock, on the `data_in`/`data_in_valid` pair the convolution top consumes. It adds line and frame markers plus a completion pulse, so a controller or testbench can sequence frames back to back.

---
 rtl/image_pixel_streamer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/image_pixel_streamer.sv
// Frame buffer plus raster replayer: stores one IMG_WIDTH x IMG_HEIGHT frame and
// streams it one pixel per clock with row/frame markers and a completion pulse.
module image_pixel_streamer #(
  parameter int IMG_WIDTH  = 3,
  parameter int IMG_HEIGHT = 3,
  parameter int DATA_SIZE  = 8,
  localparam int NUM_PIX   = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW        = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 start,
  output logic [DATA_SIZE-1:0] pixel_out,
  output logic                 pixel_valid,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  // Handshake: pixel_valid marks a pixel on pixel_out for exactly one cycle;
  // there is no ready, the consumer must take every valid pixel.
  state_t               state, state_n;
  logic [AW-1:0]        ptr, ptr_n;
  logic [CW-1:0]        col, col_n;
  logic [RW-1:0]        row, row_n;
  logic [DATA_SIZE-1:0] pix_n;
  logic                 valid_n, eol_n, eof_n, busy_n, done_n;
  logic                 wr_ok;

  logic [DATA_SIZE-1:0] pix_mem [NUM_PIX];

  assign wr_ok = wr_en && (state == IDLE) && !start && (32'(wr_addr) < 32'(NUM_PIX));

  // Buffer has no reset so a stored frame survives rst.
  always_ff @(posedge clk) begin
    if (wr_ok) pix_mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    col_n   = col;
    row_n   = row;
    pix_n   = '0;
    valid_n = 1'b0;
    eol_n   = 1'b0;
    eof_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = STREAM;
          pix_n   = pix_mem[0];
          valid_n = 1'b1;
          ptr_n   = AW'(1);
          col_n   = '0;
          row_n   = '0;
          eol_n   = (IMG_WIDTH == 1);
          eof_n   = (NUM_PIX == 1);
          busy_n  = 1'b1;
        end
      end
      STREAM: begin
        busy_n = 1'b1;
        // eof on the presented pixel means the frame has just been emitted.
        if (eof) begin
          state_n = DONE;
          done_n  = 1'b1;
          ptr_n   = '0;
          col_n   = '0;
          row_n   = '0;
        end else begin
          pix_n   = pix_mem[ptr];
          valid_n = 1'b1;
          ptr_n   = ptr + AW'(1);
          if (col == COL_LAST) begin
            col_n = '0;
            row_n = row + RW'(1);
          end else begin
            col_n = col + CW'(1);
          end
          eol_n = (col_n == COL_LAST);
          eof_n = (col_n == COL_LAST) && (row_n == ROW_LAST);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      col         <= '0;
      row         <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      col         <= col_n;
      row         <= row_n;
      pixel_out   <= pix_n;
      pixel_valid <= valid_n;
      eol         <= eol_n;
      eof         <= eof_n;
      busy        <= busy_n;
      frame_done  <= done_n;
    end
  end

endmodule
